// File: rtl/fir_ctrl_pkg.sv
// Shared types and defaults for the FIR coefficient SRAM controller.
package fir_ctrl_pkg;

    localparam int COEF_NUM_DEF = 10;
    localparam int ADDR_W_DEF   = 4;
    localparam int DATA_W_DEF   = 16;

    // Deselected / read levels of the active-low SRAM strobes
    localparam logic RAM_CSN_IDLE = 1'b1;
    localparam logic RAM_WRN_IDLE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_ACK
    } state_t;

endpackage

// File: rtl/fir_coef_sram_ctrl_if.sv
// Bundle of sweep, host-update and SRAM pins; master = controller side.
interface fir_coef_sram_ctrl_if
    import fir_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              start;
    logic              busy;
    logic              coef_valid;
    logic [DATA_W-1:0] coef_data;
    logic [ADDR_W-1:0] coef_idx;
    logic              sweep_done;
    logic              overrun;
    logic              upd_req;
    logic [ADDR_W-1:0] upd_addr;
    logic [DATA_W-1:0] upd_data;
    logic              upd_ack;
    logic              upd_err;
    logic              ram_csn;
    logic              ram_wrn;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        input  start, upd_req, upd_addr, upd_data, ram_rdata,
        output busy, coef_valid, coef_data, coef_idx, sweep_done, overrun,
               upd_ack, upd_err, ram_csn, ram_wrn, ram_addr, ram_wdata
    );

    modport slave (
        output start, upd_req, upd_addr, upd_data, ram_rdata,
        input  busy, coef_valid, coef_data, coef_idx, sweep_done, overrun,
               upd_ack, upd_err, ram_csn, ram_wrn, ram_addr, ram_wdata
    );

endinterface

// File: rtl/fir_coef_addr_gen.sv
// Sweep address counter; FIR_SWEEP_REVERSE_EN selects descending order.
module fir_coef_addr_gen
    import fir_ctrl_pkg::*;
#(
    parameter int COEF_NUM = COEF_NUM_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_nxt,
    output logic              last
);
`ifdef FIR_SWEEP_REVERSE_EN
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(COEF_NUM - 1);
    localparam logic [ADDR_W-1:0] FINAL = '0;
`else
    localparam logic [ADDR_W-1:0] FIRST = '0;
    localparam logic [ADDR_W-1:0] FINAL = ADDR_W'(COEF_NUM - 1);
`endif

    assign last = (addr == FINAL);

    // Stepping past the terminal count reloads, so no address beyond the table is ever produced
    always_comb begin
        addr_nxt = addr;
        if (load || (step && last)) begin
            addr_nxt = FIRST;
        end else if (step) begin
`ifdef FIR_SWEEP_REVERSE_EN
            addr_nxt = addr - ADDR_W'(1);
`else
            addr_nxt = addr + ADDR_W'(1);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else begin
            addr <= addr_nxt;
        end
    end

endmodule

// File: rtl/fir_coef_sram_ctrl.sv
// Coefficient SRAM controller: read sweeps on start, host writes between sweeps.
// Sweep direction set by FIR_SWEEP_REVERSE_EN inside fir_coef_addr_gen.
//
// state   | meaning
// S_IDLE  | RAM deselected, start has priority over update request
// S_READ  | one coefficient address issued per cycle
// S_DRAIN | RAM deselected, last read word returns
// S_WRITE | single write strobe (suppressed for out-of-range address)
// S_ACK   | update acknowledge (+ error) pulse
module fir_coef_sram_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int COEF_NUM = COEF_NUM_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
)(
    input  logic                 clk,
    input  logic                 rst,
    fir_coef_sram_ctrl_if.master bus
);
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(COEF_NUM - 1);

    state_t state, state_nxt;
    logic load, step, last;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic wr_ok, wr_err;
    logic csn_q, wrn_q, csn_nxt, wrn_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic busy_q, valid_q, done_q, overrun_q, ack_q, err_q;
    logic [ADDR_W-1:0] idx_q;

    assign wr_ok = (bus.upd_addr <= MAX_ADDR);

    fir_coef_addr_gen #(.COEF_NUM(COEF_NUM), .ADDR_W(ADDR_W)) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .addr     (cnt),
        .addr_nxt (cnt_nxt),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_READ;
                    load      = 1'b1;
                end else if (bus.upd_req) begin
                    state_nxt = S_WRITE;
                end
            end
            S_READ: begin
                step = 1'b1;
                if (last) state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = S_IDLE;
            S_WRITE: state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // SRAM pins are computed from the next state so they leave a flop in the state's own cycle
    always_comb begin
        csn_nxt   = RAM_CSN_IDLE;
        wrn_nxt   = RAM_WRN_IDLE;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        if (state_nxt == S_READ) begin
            csn_nxt  = 1'b0;
            addr_nxt = cnt_nxt;
        end else if (state == S_IDLE && state_nxt == S_WRITE && wr_ok) begin
            csn_nxt   = 1'b0;
            wrn_nxt   = 1'b0;
            addr_nxt  = bus.upd_addr;
            wdata_nxt = bus.upd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csn_q     <= RAM_CSN_IDLE;
            wrn_q     <= RAM_WRN_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            csn_q     <= csn_nxt;
            wrn_q     <= wrn_nxt;
            addr_q    <= addr_nxt;
            wdata_q   <= wdata_nxt;
            busy_q    <= (state_nxt != S_IDLE);
            valid_q   <= (state == S_READ);
            done_q    <= (state == S_READ) && last;
            overrun_q <= bus.start && (state != S_IDLE);
            ack_q     <= (state_nxt == S_ACK);
            err_q     <= (state_nxt == S_ACK) && wr_err;
            if (state == S_READ) idx_q <= cnt;
            if (state == S_IDLE && state_nxt == S_WRITE) wr_err <= !wr_ok;
        end
    end

    assign bus.ram_csn    = csn_q;
    assign bus.ram_wrn    = wrn_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_wdata  = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.coef_valid = valid_q;
    assign bus.coef_idx   = idx_q;
    assign bus.coef_data  = bus.ram_rdata;
    assign bus.sweep_done = done_q;
    assign bus.overrun    = overrun_q;
    assign bus.upd_ack    = ack_q;
    assign bus.upd_err    = err_q;

endmodule

// File: tb/tb_fir_coef_sram_ctrl.sv
// Directed bench for fir_coef_sram_ctrl with a behavioural 16x16 SRAM.
module tb_fir_coef_sram_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fir_coef_sram_ctrl_if #(.ADDR_W(4), .DATA_W(16)) bus ();

    fir_coef_sram_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:15];
    bit          oob;
    always @(posedge clk) begin
        if (!bus.ram_csn) begin
            if (bus.ram_addr > 4'd9) oob <= 1'b1;
            if (!bus.ram_wrn) mem[bus.ram_addr] <= bus.ram_wdata;
            else              bus.ram_rdata     <= mem[bus.ram_addr];
        end
    end

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        bit          exp_err;
    } wr_vec_t;

    logic [15:0] exp_mem [0:9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int order(input int k);
`ifdef FIR_SWEEP_REVERSE_EN
        return 9 - k;
`else
        return k;
`endif
    endfunction

    task automatic do_write(input logic [3:0] a, input logic [15:0] d, input bit exp_err);
        bus.upd_req  = 1'b1;
        bus.upd_addr = a;
        bus.upd_data = d;
        tick();
        chk("wr_csn", 32'(bus.ram_csn), 32'(exp_err));
        chk("wr_ack_early", 32'(bus.upd_ack), 32'd0);
        if (!exp_err) begin
            chk("wr_wrn", 32'(bus.ram_wrn), 32'd0);
            chk("wr_addr", 32'(bus.ram_addr), 32'(a));
            chk("wr_data", 32'(bus.ram_wdata), 32'(d));
        end
        tick();
        chk("wr_ack", 32'(bus.upd_ack), 32'd1);
        chk("wr_err", 32'(bus.upd_err), 32'(exp_err));
        chk("wr_ack_csn", 32'(bus.ram_csn), 32'd1);
        bus.upd_req = 1'b0;
        tick();
        chk("wr_ack_end", 32'(bus.upd_ack), 32'd0);
        chk("wr_busy_end", 32'(bus.busy), 32'd0);
        if (!exp_err) exp_mem[a] = d;
    endtask

    // inj >= 0 pulses start again in cycle T+1+inj (mid-sweep)
    task automatic do_sweep(input int inj);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("sw_busy", 32'(bus.busy), 32'd1);
        for (int k = 0; k < 10; k++) begin
            chk("sw_csn", 32'(bus.ram_csn), 32'd0);
            chk("sw_wrn", 32'(bus.ram_wrn), 32'd1);
            chk("sw_addr", 32'(bus.ram_addr), 32'(order(k)));
            if (k == inj) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            chk("sw_valid", 32'(bus.coef_valid), 32'd1);
            chk("sw_idx", 32'(bus.coef_idx), 32'(order(k)));
            chk("sw_data", 32'(bus.coef_data), 32'(exp_mem[order(k)]));
            chk("sw_done", 32'(bus.sweep_done), 32'(k == 9));
            chk("sw_overrun", 32'(bus.overrun), 32'(k == inj));
        end
        chk("sw_drain_csn", 32'(bus.ram_csn), 32'd1);
        chk("sw_drain_busy", 32'(bus.busy), 32'd1);
        tick();
        chk("sw_end_busy", 32'(bus.busy), 32'd0);
        chk("sw_end_valid", 32'(bus.coef_valid), 32'd0);
        chk("sw_end_done", 32'(bus.sweep_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        wr_vec_t wr_tab [12];
        for (int i = 0; i < 10; i++) begin
            wr_tab[i].addr    = 4'(i);
            wr_tab[i].data    = 16'h0A00 + 16'(i);
            wr_tab[i].exp_err = 1'b0;
        end
        wr_tab[10] = '{addr: 4'd12, data: 16'hBEEF, exp_err: 1'b1};
        wr_tab[11] = '{addr: 4'd15, data: 16'hDEAD, exp_err: 1'b1};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.upd_req  = 1'b0;
        bus.upd_addr = '0;
        bus.upd_data = '0;
        #12;
        chk("rst_csn", 32'(bus.ram_csn), 32'd1);
        chk("rst_wrn", 32'(bus.ram_wrn), 32'd1);
        chk("rst_addr", 32'(bus.ram_addr), 32'd0);
        chk("rst_wdata", 32'(bus.ram_wdata), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.coef_valid), 32'd0);
        chk("rst_idx", 32'(bus.coef_idx), 32'd0);
        chk("rst_done", 32'(bus.sweep_done), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_ack", 32'(bus.upd_ack), 32'd0);
        chk("rst_err", 32'(bus.upd_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Table of host writes, including two out-of-range addresses
        for (int i = 0; i < 12; i++) do_write(wr_tab[i].addr, wr_tab[i].data, wr_tab[i].exp_err);

        do_sweep(-1);

        // Start and update in the same IDLE cycle: sweep first, write after
        bus.upd_req  = 1'b1;
        bus.upd_addr = 4'd3;
        bus.upd_data = 16'h1234;
        do_sweep(-1);
        tick();
        chk("pend_csn", 32'(bus.ram_csn), 32'd0);
        chk("pend_wrn", 32'(bus.ram_wrn), 32'd0);
        chk("pend_addr", 32'(bus.ram_addr), 32'd3);
        chk("pend_data", 32'(bus.ram_wdata), 32'h1234);
        tick();
        chk("pend_ack", 32'(bus.upd_ack), 32'd1);
        chk("pend_err", 32'(bus.upd_err), 32'd0);
        bus.upd_req = 1'b0;
        tick();
        exp_mem[3] = 16'h1234;
        do_sweep(-1);

        // Start arriving mid-sweep is dropped
        do_sweep(4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ovr_no_resweep_busy", 32'(bus.busy), 32'd0);
            chk("ovr_no_resweep_valid", 32'(bus.coef_valid), 32'd0);
            chk("ovr_quiet", 32'(bus.overrun), 32'd0);
        end

        // Reset mid-sweep
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_idx", 32'(bus.coef_idx), 32'(order(4)));
        chk("mid_valid", 32'(bus.coef_valid), 32'd1);
        rst = 1'b1;
        #2;
        chk("arst_csn", 32'(bus.ram_csn), 32'd1);
        chk("arst_valid", 32'(bus.coef_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.sweep_done), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_hold_done", 32'(bus.sweep_done), 32'd0);
            chk("rst_hold_csn", 32'(bus.ram_csn), 32'd1);
        end
        rst = 1'b0;
        tick();
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        do_sweep(-1);

        chk("no_oob_access", 32'(oob), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
